// File: rtl/wb_tlc_credit_track.sv
// wb_tlc_credit_track
//   Receive-side flow-control gate for the WB-side receive buffer (clk_125 domain).
//   A TLP is admitted only when a buffer slot is free and enough dword credits
//   remain. Each admitted TLP length is remembered in a small FIFO so that a
//   returned-credit pulse can give back exactly the dwords that TLP consumed.
//
// Ports
//   clk_125      in   1       clock for all logic
//   rstn         in   1       synchronous active-low reset
//   tlp_req      in   1       admit request, held until tlp_gnt
//   tlp_len      in   10      payload length in dwords, 0 means 1024
//   tlp_gnt      out  1       one-cycle grant (credits debited on the same edge)
//   cr_125       in   1       one-cycle credit-return pulse
//   slots_avail  out  SLOT_W  free TLP slots
//   dw_avail     out  DW_W    free dword credits
//   credit_err   out  1       sticky: credit returned with nothing outstanding
//   idle         out  1       no TLP outstanding
//   fsm_state    out  1       debug view of the grant FSM (0 = IDLE, 1 = GRANT)
//
// Handshake: tlp_req/tlp_len form a request that the requester holds stable
// until the cycle tlp_gnt is high; the transfer happens on the edge that
// raises tlp_gnt. The FSM ignores tlp_req while tlp_gnt is high, so the
// requester may present the next tlp_len during that cycle.

module wb_tlc_credit_track #(
  parameter int NUM_SLOTS    = 8,
  parameter int DATA_CREDITS = 1024,
  parameter int DW_W         = 11,
  parameter int SLOT_W       = 4
) (
  input  logic              clk_125,
  input  logic              rstn,
  input  logic              tlp_req,
  input  logic [9:0]        tlp_len,
  output logic              tlp_gnt,
  input  logic              cr_125,
  output logic [SLOT_W-1:0] slots_avail,
  output logic [DW_W-1:0]   dw_avail,
  output logic              credit_err,
  output logic              idle,
  output logic              fsm_state
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [10:0]       len_eff;
  logic [DW_W-1:0]   len_dw;
  logic [DW_W-1:0]   pop_dw;
  logic              fit;
  logic              push;
  logic              pop;
  logic              err_evt;
  logic [SLOT_W-1:0] slots_d;
  logic [DW_W:0]     dw_sum;
  logic [DW_W-1:0]   dw_d;

  logic [10:0]       fifo_mem [NUM_SLOTS];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign len_eff = (tlp_len == 10'd0) ? 11'd1024 : {1'b0, tlp_len};
  assign len_dw  = DW_W'(len_eff);
  assign pop_dw  = DW_W'(fifo_mem[rd_ptr]);

  // Registered counters only: a credit returned this cycle cannot help a TLP fit.
  assign fit = (slots_avail != '0) && (len_dw <= dw_avail);

  // A full slot count means nothing is outstanding, so a return is bogus.
  assign pop     = cr_125 && (slots_avail != SLOT_W'(NUM_SLOTS));
  assign err_evt = cr_125 && (slots_avail == SLOT_W'(NUM_SLOTS));

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tlp_req && fit) begin
          state_d = ST_GRANT;
          push    = 1'b1;
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slots_d = slots_avail;
    case ({push, pop})
      2'b10:   slots_d = slots_avail - SLOT_W'(1);
      2'b01:   slots_d = slots_avail + SLOT_W'(1);
      default: slots_d = slots_avail;
    endcase
  end

  // One bit of headroom so the add-then-subtract never wraps mid-way.
  always_comb begin
    dw_sum = {1'b0, dw_avail};
    if (pop)  dw_sum = dw_sum + {1'b0, pop_dw};
    if (push) dw_sum = dw_sum - {1'b0, len_dw};
    dw_d = dw_sum[DW_W-1:0];
  end

  always_ff @(posedge clk_125) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      slots_avail <= SLOT_W'(NUM_SLOTS);
      dw_avail    <= DW_W'(DATA_CREDITS);
      credit_err  <= 1'b0;
      idle        <= 1'b1;
    end else begin
      state_q     <= state_d;
      slots_avail <= slots_d;
      dw_avail    <= dw_d;
      idle        <= (slots_d == SLOT_W'(NUM_SLOTS));
      if (push)    wr_ptr     <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr     <= rd_ptr + PTR_W'(1);
      if (err_evt) credit_err <= 1'b1;
    end
  end

  // Length storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_125) begin
    if (rstn && push) fifo_mem[wr_ptr] <= len_eff;
  end

  assign tlp_gnt   = (state_q == ST_GRANT);
  assign fsm_state = state_q;

`ifndef SYNTHESIS
  a_slots_max: assert property (@(posedge clk_125) disable iff (!rstn)
    slots_avail <= SLOT_W'(NUM_SLOTS));
  a_dw_max: assert property (@(posedge clk_125) disable iff (!rstn)
    dw_avail <= DW_W'(DATA_CREDITS));
  a_dw_no_wrap: assert property (@(posedge clk_125) disable iff (!rstn)
    dw_sum <= (DW_W+1)'(DATA_CREDITS));
`endif

endmodule

// File: tb/tb_wb_tlc_credit_track.sv
module tb_wb_tlc_credit_track;

  logic        clk_125 = 1'b0;
  logic        rstn;
  logic        tlp_req;
  logic [9:0]  tlp_len;
  logic        tlp_gnt;
  logic        cr_125;
  logic [3:0]  slots_avail;
  logic [10:0] dw_avail;
  logic        credit_err;
  logic        idle;
  logic        fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_125 = ~clk_125;

  wb_tlc_credit_track dut (
    .clk_125     (clk_125),
    .rstn        (rstn),
    .tlp_req     (tlp_req),
    .tlp_len     (tlp_len),
    .tlp_gnt     (tlp_gnt),
    .cr_125      (cr_125),
    .slots_avail (slots_avail),
    .dw_avail    (dw_avail),
    .credit_err  (credit_err),
    .idle        (idle),
    .fsm_state   (fsm_state)
  );

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge; inputs change and
  // outputs are sampled there, well away from the edge.
  task automatic step();
    @(posedge clk_125);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    tlp_req = 1'b0;
    tlp_len = 10'd0;
    cr_125  = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic gnt, input int slots,
                         input int dw, input logic err, input logic idl);
    chk({tag, ".gnt"},   32'(tlp_gnt),     32'(gnt));
    chk({tag, ".slots"}, 32'(slots_avail), 32'(slots));
    chk({tag, ".dw"},    32'(dw_avail),    32'(dw));
    chk({tag, ".err"},   32'(credit_err),  32'(err));
    chk({tag, ".idle"},  32'(idle),        32'(idl));
  endtask

  initial begin
    // ---------- test 1: reset values and first grant ----------
    rstn = 1'b0; tlp_req = 1'b0; tlp_len = 10'd0; cr_125 = 1'b0;
    step();
    chk_all("t1_reset", 1'b0, 8, 1024, 1'b0, 1'b1);
    chk("t1_reset.state", 32'(fsm_state), 32'd0);
    step();
    rstn = 1'b1; tlp_req = 1'b1; tlp_len = 10'd16;   // cycle 0
    step();                                          // cycle 1
    chk_all("t1_grant", 1'b1, 7, 1008, 1'b0, 1'b0);
    chk("t1_grant.state", 32'(fsm_state), 32'd1);
    tlp_req = 1'b0;
    step();
    chk_all("t1_after", 1'b0, 7, 1008, 1'b0, 1'b0);

    // ---------- test 2: slot exhaustion ----------
    do_reset();
    tlp_req = 1'b1; tlp_len = 10'd4;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t2_gnt%0d", i), 32'(tlp_gnt), 32'd1);
      chk($sformatf("t2_slots%0d", i), 32'(slots_avail), 32'(7 - i));
      step();
      chk($sformatf("t2_gap%0d", i), 32'(tlp_gnt), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("t2_stall%0d", i), 1'b0, 0, 992, 1'b0, 1'b0);
    end
    cr_125 = 1'b1;
    step();
    cr_125 = 1'b0;
    chk_all("t2_ret", 1'b0, 1, 996, 1'b0, 1'b0);
    step();
    chk_all("t2_gnt9", 1'b1, 0, 992, 1'b0, 1'b0);
    tlp_req = 1'b0;
    // drain two more to exercise the read pointer past the refilled entry
    cr_125 = 1'b1;
    step();
    step();
    cr_125 = 1'b0;
    chk_all("t2_drain2", 1'b0, 2, 1000, 1'b0, 1'b0);

    // ---------- test 3: dword exhaustion, len 0 = 1024 ----------
    do_reset();
    tlp_req = 1'b1; tlp_len = 10'd100;
    step();
    chk_all("t3_gnt100", 1'b1, 7, 924, 1'b0, 1'b0);
    tlp_len = 10'd0;                                 // next TLP during grant
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("t3_stall%0d", i), 1'b0, 7, 924, 1'b0, 1'b0);
    end
    cr_125 = 1'b1;
    step();
    cr_125 = 1'b0;
    chk_all("t3_ret", 1'b0, 8, 1024, 1'b0, 1'b1);
    step();
    chk_all("t3_gnt1024", 1'b1, 7, 0, 1'b0, 1'b0);
    tlp_req = 1'b0;
    step();
    chk_all("t3_after", 1'b0, 7, 0, 1'b0, 1'b0);

    // ---------- test 4: debit and return on one edge ----------
    do_reset();
    tlp_req = 1'b1; tlp_len = 10'd8;
    step();
    chk_all("t4_gnt8", 1'b1, 7, 1016, 1'b0, 1'b0);
    tlp_len = 10'd32;
    step();
    chk_all("t4_gap", 1'b0, 7, 1016, 1'b0, 1'b0);
    cr_125 = 1'b1;
    step();
    cr_125 = 1'b0; tlp_req = 1'b0;
    chk_all("t4_both", 1'b1, 7, 992, 1'b0, 1'b0);

    // ---------- test 5: spurious return ----------
    do_reset();
    cr_125 = 1'b1;
    step();
    cr_125 = 1'b0;
    chk_all("t5_err", 1'b0, 8, 1024, 1'b1, 1'b1);
    step();
    step();
    chk_all("t5_sticky", 1'b0, 8, 1024, 1'b1, 1'b1);

    // ---------- test 6: reset mid-operation ----------
    do_reset();
    tlp_req = 1'b1; tlp_len = 10'd10;
    for (int i = 0; i < 5; i++) step();
    tlp_req = 1'b0;
    chk_all("t6_out3", 1'b1, 5, 994, 1'b0, 1'b0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk_all("t6_reset", 1'b0, 8, 1024, 1'b0, 1'b1);
    cr_125 = 1'b1;
    step();
    cr_125 = 1'b0;
    chk_all("t6_err", 1'b0, 8, 1024, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
